// File: rtl/compinput_packer.sv
// Byte-stream front end for compressor_top: collects one message, bursts it as 16-byte
// words on consecutive cycles, then waits for a rising Done before taking the next message.
module compinput_packer #(
  parameter int unsigned STRINGSIZE = 88,
  localparam int unsigned NW = (STRINGSIZE + 15) / 16,
  localparam int unsigned LW = $clog2(STRINGSIZE + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             valid,
  output logic [15:0][7:0] CurByte,
  input  logic             Done,
  output logic [LW-1:0]    msg_len,
  output logic             truncated,
  output logic             busy
);

  localparam int unsigned IW = $clog2(NW * 16);

  typedef enum logic [1:0] {StFill, StDrain, StBurst, StWaitDone} stateT;

  stateT            stateQ, stateD;
  logic [LW-1:0]    cntQ, cntD;
  logic             truncQ, truncD;
  logic [LW:0]      wordIdxQ, wordIdxD, emitIdx, numWords;
  logic             validQ, validD;
  logic [15:0][7:0] curByteQ, curByteD;
  logic             inReadyQ, busyQ, doneQ;
  logic [LW-1:0]    msgLenQ;
  logic             accept, wrEn, emit;
  logic [LW+4:0]    pos;
  logic [7:0]       buffer [NW*16];

  assign accept   = in_valid && inReadyQ;
  assign numWords = ({1'b0, cntQ} + (LW+1)'(15)) >> 4;

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    truncD   = truncQ;
    wordIdxD = wordIdxQ;
    validD   = validQ;
    curByteD = curByteQ;
    wrEn     = 1'b0;
    emit     = 1'b0;
    emitIdx  = wordIdxQ;
    pos      = '0;

    unique case (stateQ)
      StFill: begin
        if (accept) begin
          wrEn = 1'b1;
          cntD = cntQ + LW'(1);
          if (in_last) begin
            stateD  = StBurst;
            emit    = 1'b1;
            emitIdx = '0;
          end else if (cntQ + LW'(1) == LW'(STRINGSIZE)) begin
            truncD = 1'b1;
            stateD = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept && in_last) begin
          stateD  = StBurst;
          emit    = 1'b1;
          emitIdx = '0;
        end
      end
      StBurst: begin
        if (wordIdxQ < numWords) begin
          emit = 1'b1;
        end else begin
          validD = 1'b0;
          stateD = StWaitDone;
        end
      end
      StWaitDone: begin
        if (Done && !doneQ) begin
          stateD = StFill;
          cntD   = '0;
          truncD = 1'b0;
        end
      end
      default: stateD = StFill;
    endcase

    // Padding comes purely from the count compare; stale buffer bytes are masked.
    // The final byte of a message is written on the same edge word 0 launches, so bypass it.
    if (emit) begin
      validD   = 1'b1;
      wordIdxD = emitIdx + (LW+1)'(1);
      for (int k = 0; k < 16; k++) begin
        pos = {emitIdx, 4'(k)};
        if (pos < {5'b0, cntD}) begin
          if (wrEn && pos == {5'b0, cntQ}) curByteD[k] = in_byte;
          else                             curByteD[k] = buffer[IW'(pos)];
        end else begin
          curByteD[k] = 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ   <= StFill;
      cntQ     <= '0;
      truncQ   <= 1'b0;
      wordIdxQ <= '0;
      validQ   <= 1'b0;
      curByteQ <= '0;
      inReadyQ <= 1'b0;
      busyQ    <= 1'b0;
      msgLenQ  <= '0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      truncQ   <= truncD;
      wordIdxQ <= wordIdxD;
      validQ   <= validD;
      curByteQ <= curByteD;
      inReadyQ <= (stateD == StFill) || (stateD == StDrain);
      busyQ    <= (stateD == StBurst) || (stateD == StWaitDone);
      msgLenQ  <= (cntD > LW'(STRINGSIZE)) ? LW'(STRINGSIZE) : cntD;
      doneQ    <= Done;
    end
  end

  always_ff @(posedge clock) begin
    if (wrEn) buffer[IW'(cntQ)] <= in_byte;
  end

  assign in_ready  = inReadyQ;
  assign valid     = validQ;
  assign CurByte   = curByteQ;
  assign msg_len   = msgLenQ;
  assign truncated = truncQ;
  assign busy      = busyQ;

endmodule

// File: doc/compinput_packer.md
# compinput_packer

Byte-stream front end for `compressor_top`. Accepts one message byte per cycle over a valid/ready handshake and buffers up to STRINGSIZE bytes. It then bursts the message to the compressor as 16-byte words on consecutive cycles, with `valid` held high and the tail zero-padded. It holds off the next message until the compressor's `Done` rises.

## Interface
- STRINGSIZE, 88: max message bytes; must match compressor_top.
- NW (localparam): ceil(STRINGSIZE/16), buffer depth in 16-byte words.
- LW (localparam): $clog2(STRINGSIZE+1), width of length fields.

Ports (clock, reset first):
- clock  in  1  sole clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  packer accepts byte; transfer when in_valid && in_ready.
- in_byte  in  8  message byte.
- in_last  in  1  qualifies final byte of message.
- valid  out  1  to compressor_top valid.
- CurByte  out  [15:0][7:0]  to compressor_top; CurByte[k] = message byte 16*w+k.
- Done  in  1  from compressor_top.
- msg_len  out  LW  accepted (kept) byte count of current frame.
- truncated  out  1  current frame exceeded STRINGSIZE.
- busy  out  1  high in BURST and WAIT_DONE.

## Operation
- States: FILL, DRAIN, BURST, WAIT_DONE. Reset state is FILL.
- FILL, byte accepted:
  - Write byte to buffer[cnt] and increment cnt.
  - If in_last: go to BURST.
  - Else if cnt+1 == STRINGSIZE: set truncated and go to DRAIN.
- DRAIN:
  - Accept and discard bytes.
  - On an accepted byte with in_last: go to BURST.
- BURST:
  - Emit words w = 0 .. ceil(cnt/16)-1, one per cycle.
  - Positions >= cnt in the final word are driven 0x00.
  - After the last word: valid drops and the state goes to WAIT_DONE.
- WAIT_DONE:
  - Leave on a rising edge of Done (Done=1, registered Done=0).
  - Then clear cnt and truncated, and go to FILL.
  - A Done level held from a previous frame does not release the packer.
  - Done is ignored in FILL, DRAIN and BURST.
- Buffer contents beyond cnt are never emitted. No clear is needed between frames; padding comes from the cnt compare.
- msg_len = cnt, saturating at STRINGSIZE. Stable from BURST entry until the WAIT_DONE exit.
- Reset outputs: in_ready=0, valid=0, CurByte=0, msg_len=0, truncated=0, busy=0.

## Timing
- All outputs are registered.
- in_ready is high in every cycle whose state is FILL or DRAIN, starting the first cycle after reset deasserts.
- in_ready drops the cycle after the accepted last byte (cycle t). Bytes presented while in_ready=0 are not consumed.
- Burst timing:
  - valid=1 with word 0 at t+1.
  - Word w at t+1+w, back to back with no gaps.
  - valid=0 at t+1+W, where W = ceil(cnt/16).
- CurByte holds its last value when valid=0.
- in_valid gaps in FILL/DRAIN only stall the count; the output burst is unaffected.
- Reset mid-frame (any state) is sampled at the clock edge and takes effect on the next cycle:
  - State returns to FILL and cnt is cleared.
  - valid goes low immediately; any partial burst is abandoned.
  - All outputs take their reset values.
- Boundaries:
  - cnt a multiple of 16: no pad word.
  - in_last on byte STRINGSIZE: goes straight to BURST with truncated=0.
  - in_last on the byte after STRINGSIZE: that byte is discarded and truncated=1.

## Test plan
- 88-byte string "daddy finger daddy finger where are you, here I am, here I am where are you.\n new line\0", in_last on byte 88:
  - valid high for exactly 6 consecutive cycles.
  - Word 5 CurByte[7:0] = last 8 chars; CurByte[15:8] = 0x00.
  - msg_len=88, truncated=0.
  - After 6 cycles, in_ready stays 0 until a Done rise, then returns to 1 the next cycle.
- 5-byte message "abcde" with in_valid toggling every other cycle:
  - One word, bytes 0-4 = "abcde", bytes 5-15 = 0x00.
  - valid high exactly 1 cycle, the cycle after the last accept.
- Exactly 16 bytes: one full word, no pad word, valid high 1 cycle, msg_len=16.
- 100-byte message:
  - Bytes 89-100 are accepted (in_ready=1) and discarded.
  - 6 words carry bytes 1-88; truncated=1, msg_len=88.
- Reset asserted one cycle into a 6-word burst:
  - Next cycle: valid=0, busy=0, in_ready=0.
  - in_ready=1 after reset drops.
  - A new 3-byte message bursts correctly with msg_len=3.
- Done held high across frame boundaries:
  - The second frame stays in WAIT_DONE until Done goes low and then high again.
